// File: rtl/radio_seq_pkg.sv
// radio_seq_pkg
// Shared types and default constants for the radio power-up sequencer.
//   seq_state_e      : 3-bit FSM state encoding (also driven out as seqState)
//   DEF_*            : default cycle constants and counter width
package radio_seq_pkg;

  localparam int STATE_W             = 3;
  localparam int DEF_LDO_RAMP_CYC    = 16;
  localparam int DEF_PLL_TIMEOUT_CYC = 200;
  localparam int DEF_RAMP_DOWN_CYC   = 4;
  localparam int DEF_CNT_W           = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_RAMP_LDO = 3'd1,
    ST_RAMP_PLL = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_DISABLE  = 3'd4,
    ST_ERROR    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/radio_seq_timer.sv
// radio_seq_timer
// Saturating up-counter shared by the LDO ramp, PLL timeout and ramp-down
// phases. Terminal count is a combinational compare against term.
// Ports:
//   ck    in   clock
//   arst  in   synchronous active-high reset (count -> 0)
//   clr   in   synchronous clear (count -> 0)
//   en    in   count enable
//   term  in   CNT_W terminal-count compare value
//   tc    out  1 when count == term
module radio_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Holds at all-ones so a long lock wait can never wrap back into a
  // spurious terminal-count match.
  always_ff @(posedge ck) begin
    if (arst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/radio_ramp_seq.sv
// radio_ramp_seq
// Radio power-up / power-down sequencer: LDO ramp, PLL enable and lock wait,
// RX/TX enable, then ordered ramp-down when the request drops.
// Optional build macro: RADIO_SEQ_PLL_TIMEOUT_EN (PLL lock timeout -> ERROR).
// Ports:
//   ck, arst                 clock, synchronous active-high reset
//   isolate                  1 = clamp functional outputs to 0 (FSM keeps running)
//   radioEnable, radioRxEn   request and mode (1 = RX) from the timing engine
//   pllLock                  PLL lock indicator
//   ldoEn, pllEn, rxOn, txOn radio supply / enable controls
//   radioReady, timeoutErr   status (ACTIVE, ERROR)
//   seqState                 current state encoding (debug)
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | all off, waiting for radioEnable
// RAMP_LDO | LDO on, waiting LDO_RAMP_CYC cycles
// RAMP_PLL | LDO + PLL on, waiting for pllLock
// ACTIVE   | radio up, RX or TX per latched mode
// DISABLE  | PLL off, LDO held RAMP_DOWN_CYC cycles
// ERROR    | PLL lock timeout, waiting for radioEnable low
module radio_ramp_seq
  import radio_seq_pkg::*;
#(
  parameter int LDO_RAMP_CYC    = DEF_LDO_RAMP_CYC,
  parameter int PLL_TIMEOUT_CYC = DEF_PLL_TIMEOUT_CYC,
  parameter int RAMP_DOWN_CYC   = DEF_RAMP_DOWN_CYC,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic         ck,
  input  logic         arst,
  input  logic         isolate,
  input  logic         radioEnable,
  input  logic         radioRxEn,
  input  logic         pllLock,
  output logic         ldoEn,
  output logic         pllEn,
  output logic         rxOn,
  output logic         txOn,
  output logic         radioReady,
  output logic         timeoutErr,
  output logic [2:0]   seqState
);

  seq_state_e       state_q, state_d;
  logic             mode_q, mode_ld;
  logic             tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_term;
  logic             ldo_raw, pll_raw, rx_raw, tx_raw, rdy_raw, err_raw;

  always_ff @(posedge ck) begin
    if (arst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mode_ld) begin
        mode_q <= radioRxEn;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_ld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (radioEnable) begin
          state_d = ST_RAMP_LDO;
          mode_ld = 1'b1;
        end
      end
      ST_RAMP_LDO: begin
        if (!radioEnable)  state_d = ST_DISABLE;
        else if (tmr_tc)   state_d = ST_RAMP_PLL;
      end
      ST_RAMP_PLL: begin
        if (!radioEnable)  state_d = ST_DISABLE;
        else if (pllLock)  state_d = ST_ACTIVE;
`ifdef RADIO_SEQ_PLL_TIMEOUT_EN
        else if (tmr_tc)   state_d = ST_ERROR;
`endif
      end
      ST_ACTIVE: begin
        if (!radioEnable)  state_d = ST_DISABLE;
      end
      ST_DISABLE: begin
        if (tmr_tc)        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (!radioEnable)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every state change restarts the shared counter at 0 for the new phase.
  assign tmr_clr = (state_d != state_q) || (state_q == ST_IDLE);
  assign tmr_en  = (state_q != ST_IDLE);

  always_comb begin
    tmr_term = '0;
    case (state_q)
      ST_RAMP_LDO: tmr_term = CNT_W'(LDO_RAMP_CYC - 1);
      ST_RAMP_PLL: tmr_term = CNT_W'(PLL_TIMEOUT_CYC - 1);
      ST_DISABLE:  tmr_term = CNT_W'(RAMP_DOWN_CYC - 1);
      default:     tmr_term = '0;
    endcase
  end

  radio_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .ck   (ck),
    .arst (arst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .term (tmr_term),
    .tc   (tmr_tc)
  );

  always_comb begin
    ldo_raw = 1'b0;
    pll_raw = 1'b0;
    rx_raw  = 1'b0;
    tx_raw  = 1'b0;
    rdy_raw = 1'b0;
    err_raw = 1'b0;
    case (state_q)
      ST_RAMP_LDO: ldo_raw = 1'b1;
      ST_RAMP_PLL: begin
        ldo_raw = 1'b1;
        pll_raw = 1'b1;
      end
      ST_ACTIVE: begin
        ldo_raw = 1'b1;
        pll_raw = 1'b1;
        rdy_raw = 1'b1;
        rx_raw  = mode_q;
        tx_raw  = !mode_q;
      end
      ST_DISABLE: ldo_raw = 1'b1;
`ifdef RADIO_SEQ_PLL_TIMEOUT_EN
      ST_ERROR:   err_raw = 1'b1;
`endif
      default: ;
    endcase
  end

  assign ldoEn      = ldo_raw & !isolate;
  assign pllEn      = pll_raw & !isolate;
  assign rxOn       = rx_raw  & !isolate;
  assign txOn       = tx_raw  & !isolate;
  assign radioReady = rdy_raw & !isolate;
`ifdef RADIO_SEQ_PLL_TIMEOUT_EN
  assign timeoutErr = err_raw & !isolate;
`else
  assign timeoutErr = 1'b0;
`endif
  // Debug readback stays visible under isolation so the running FSM can be
  // observed while the radio controls are clamped.
  assign seqState   = state_q;

endmodule

// File: tb/tb_radio_ramp_seq.sv
module tb_radio_ramp_seq;

  logic       ck = 1'b0;
  logic       arst, isolate, radioEnable, radioRxEn, pllLock;
  logic       ldoEn, pllEn, rxOn, txOn, radioReady, timeoutErr;
  logic [2:0] seqState;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic done = 1'b0;

  int         q_cyc[$];
  logic [8:0] q_val[$];
  string      q_tag[$];

  radio_ramp_seq dut (
    .ck          (ck),
    .arst        (arst),
    .isolate     (isolate),
    .radioEnable (radioEnable),
    .radioRxEn   (radioRxEn),
    .pllLock     (pllLock),
    .ldoEn       (ldoEn),
    .pllEn       (pllEn),
    .rxOn        (rxOn),
    .txOn        (txOn),
    .radioReady  (radioReady),
    .timeoutErr  (timeoutErr),
    .seqState    (seqState)
  );

  initial forever #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // {ldoEn, pllEn, rxOn, txOn, radioReady, timeoutErr, seqState}
  function automatic logic [8:0] ov(logic l, logic p, logic r, logic t,
                                    logic y, logic e, logic [2:0] s);
    return {l, p, r, t, y, e, s};
  endfunction

  task automatic expect_at(int c, logic [8:0] v, string tag);
    q_cyc.push_back(c);
    q_val.push_back(v);
    q_tag.push_back(tag);
  endtask

  task automatic go(int c);
    while (cyc < c) begin
      @(posedge ck);
      #1;
    end
  endtask

  // Monitor: outputs are compared mid-cycle against the queued expectation.
  always @(negedge ck) begin
    logic [8:0] obs;
    obs = {ldoEn, pllEn, rxOn, txOn, radioReady, timeoutErr, seqState};
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      n_tests++;
      if (q_cyc[0] < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", q_tag[0], q_cyc[0], cyc);
      end else if (obs !== q_val[0]) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %b want %b (ldo pll rx tx rdy err st[2:0])",
                 q_tag[0], cyc, obs, q_val[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
      void'(q_tag.pop_front());
    end
  end

  localparam logic [8:0] OFF     = 9'b000000_000;
  localparam logic [8:0] LDO     = 9'b100000_001;
  localparam logic [8:0] PLL     = 9'b110000_010;
  localparam logic [8:0] ACT_RX  = 9'b111010_011;
  localparam logic [8:0] ACT_TX  = 9'b110110_011;
  localparam logic [8:0] DIS     = 9'b100000_100;

  initial begin
    arst = 1'b1; isolate = 1'b0; radioEnable = 1'b0; radioRxEn = 1'b0; pllLock = 1'b0;

    // Reset and RX power-up
    expect_at(3, OFF, "reset_state");
    go(3);  arst = 1'b0; radioRxEn = 1'b1;
    expect_at(10, OFF, "idle_before_req");
    expect_at(11, LDO, "ldo_rise");
    expect_at(26, LDO, "ldo_last_cycle");
    expect_at(27, PLL, "pll_rise");
    expect_at(40, PLL, "pll_wait");
    expect_at(41, ACT_RX, "active_rx");
    expect_at(47, ACT_RX, "rxen_toggle_ignored");
    expect_at(50, ov(0,0,0,0,0,0,3'd3), "isolate_clamp");
    expect_at(52, ov(0,0,0,0,0,0,3'd3), "isolate_hold");
    expect_at(53, ACT_RX, "isolate_release");
    go(10); radioEnable = 1'b1;
    go(40); pllLock = 1'b1;
    go(45); radioRxEn = 1'b0;
    go(50); isolate = 1'b1;
    go(53); isolate = 1'b0;

    // Ramp-down, re-request during DISABLE ignored then restarts in TX
    expect_at(60, ACT_RX, "before_disable");
    expect_at(61, DIS, "disable_enter");
    expect_at(64, DIS, "disable_last");
    expect_at(65, OFF, "idle_after_disable");
    expect_at(66, LDO, "restart_from_idle");
    go(60); radioEnable = 1'b0; pllLock = 1'b0;
    go(62); radioEnable = 1'b1;

    // Abort mid-LDO at cnt=5
    expect_at(71, LDO, "ldo_cnt5");
    expect_at(72, DIS, "abort_ldo_disable");
    expect_at(75, DIS, "abort_disable_last");
    expect_at(76, OFF, "abort_idle");
    go(71); radioEnable = 1'b0;

    // TX power-up, mode held against radioRxEn changes
    expect_at(96, LDO, "tx_ldo_last");
    expect_at(97, PLL, "tx_pll_rise");
    expect_at(101, ACT_TX, "active_tx");
    expect_at(105, ACT_TX, "tx_mode_held");
    expect_at(111, DIS, "tx_disable");
    expect_at(115, OFF, "tx_idle");
    go(80); radioEnable = 1'b1; radioRxEn = 1'b0;
    go(100); pllLock = 1'b1;
    go(103); radioRxEn = 1'b1;
    go(110); radioEnable = 1'b0; pllLock = 1'b0;

    // Reset mid RAMP_PLL, then new ramp once released
    expect_at(137, PLL, "pre_reset_pll");
    expect_at(141, OFF, "reset_mid_ramp");
    expect_at(142, OFF, "reset_held");
    expect_at(143, LDO, "after_reset_ramp");
    expect_at(144, DIS, "after_reset_disable");
    expect_at(148, OFF, "after_reset_idle");
    go(120); radioEnable = 1'b1;
    go(140); arst = 1'b1;
    go(142); arst = 1'b0;
    go(143); radioEnable = 1'b0;

    // Lock wait with no lock: timeout vs indefinite wait
    expect_at(166, LDO, "lw_ldo_last");
    expect_at(167, PLL, "lw_pll_rise");
    expect_at(366, PLL, "lw_cnt199");
`ifdef RADIO_SEQ_PLL_TIMEOUT_EN
    expect_at(367, ov(0,0,0,0,0,1,3'd5), "timeout_error");
    expect_at(370, ov(0,0,0,0,0,1,3'd5), "error_hold");
    expect_at(371, OFF, "error_to_idle");
    expect_at(596, PLL, "lock_tmo_cnt199");
    expect_at(597, ACT_RX, "lock_beats_timeout");
    expect_at(601, DIS, "lt_disable");
    expect_at(605, OFF, "lt_idle");
    go(150); radioEnable = 1'b1; radioRxEn = 1'b1;
    go(370); radioEnable = 1'b0;
    go(380); radioEnable = 1'b1;
    go(596); pllLock = 1'b1;
    go(600); radioEnable = 1'b0; pllLock = 1'b0;
    go(610);
`else
    expect_at(367, PLL, "no_timeout_367");
    expect_at(500, PLL, "no_timeout_saturated");
    expect_at(501, ACT_RX, "late_lock_active");
    expect_at(511, DIS, "late_disable");
    expect_at(515, OFF, "late_idle");
    go(150); radioEnable = 1'b1; radioRxEn = 1'b1;
    go(500); pllLock = 1'b1;
    go(510); radioEnable = 1'b0; pllLock = 1'b0;
    go(520);
`endif

    @(posedge ck); #1;
    while (q_cyc.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", q_tag[0], q_cyc[0]);
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
      void'(q_tag.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
